int_mac: RTL and testbench
==========================

Name: int_mac

Overview:
- Parametrised, pipelined signed multiply-accumulate unit. Successor to the combinational intadd/intmult pair.
- Streams operand pairs under a valid/ready handshake and accumulates their products into a wide accumulator. `first` and `last` markers delimit each dot product.
- On each completed dot product, emits the full accumulator plus a WIDTH-bit narrowed result with overflow flagging. Narrowing is selectable: saturate or wrap.
- Intended as the processing-element arithmetic core of the TPU datapath.

Parameters:
- WIDTH, 8: operand and narrowed-result width; signed two's complement.
- ACC_WIDTH, 20: accumulator width. Must be >= 2*WIDTH; elaboration error otherwise.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  unit can accept a beat
- a  in  WIDTH  signed operand A
- b  in  WIDTH  signed operand B
- first  in  1  beat starts a new accumulation
- last  in  1  beat ends the accumulation; result is emitted
- sat_mode  in  1  1 = saturate, 0 = wrap; sampled with each beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_acc  out  ACC_WIDTH  signed accumulator result
- out_data  out  WIDTH  narrowed signed result
- overflow  out  1  accumulator or narrowing overflow for this result

Behaviour:
- Reset (async, rst_n=0):
  - All outputs go to 0: out_valid, out_acc, out_data, overflow.
  - Stage-1 valid, accumulator and sticky overflow flag are cleared.
  - in_ready is 1 after reset releases.
  - Reset mid-accumulation discards the partial sum; no result is emitted.
- Handshake:
  - advance = !out_valid | out_ready; in_ready = advance.
  - A beat transfers on a rising edge with in_valid & in_ready.
  - A result transfers on out_valid & out_ready.
  - out_* fields hold stable while out_valid=1 and out_ready=0.
- Stage 1 (on advance):
  - Registers p = a*b as a signed 2*WIDTH product, sign-extended to ACC_WIDTH.
  - Also registers first, last, sat_mode and s1_valid = in_valid.
- Stage 2 (on advance when s1_valid):
  - base = first ? 0 : acc.
  - sum = base + p, computed at ACC_WIDTH+1 bits.
  - Accumulator overflow: sum is outside [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]. This sets the sticky flag.
  - sat_mode=1: sum is clamped to the ACC bound. sat_mode=0: low ACC_WIDTH bits are kept.
  - `first` clears the sticky flag before the new overflow is ORed in.
  - Not last: acc <= result.
  - Last: load the output register; then acc <= 0 and sticky <= 0.
    - out_acc = result.
    - out_data = narrowed result. sat_mode=1 clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat_mode=0 takes the low WIDTH bits.
    - overflow = sticky | acc overflow this beat | narrowing overflow.
    - out_valid <= 1.
- Output register: out_valid clears on an edge with out_ready=1 when no new last-result loads. A new result may load on the same edge the old one is taken.
- Latency:
  - Last beat accepted at edge N produces out_valid=1 after edge N+1.
  - With out_ready=1 held, throughput is 1 beat/cycle.
- The whole pipeline stalls together when the output is occupied and not accepted. No beat is lost or duplicated.
- A beat with first=last=1 is a single-product result.
- A non-first beat after a last accumulates from 0.

Test Plan:
1. Single beat, a=-7, b=11, first=last=1, sat_mode=1, out_ready=1 -> out_valid 2 edges after accept; out_acc=-77, out_data=8'hB3, overflow=0.
2. Single beat a=127, b=2:
   - sat_mode=1 -> out_acc=254, out_data=127, overflow=1.
   - sat_mode=0 -> out_data=8'hFE, overflow=1.
3. Back-to-back beats (2,17,first), (3,-4), (-1,-1,last) -> one result with out_acc=23, out_data=23, overflow=0.
   - A following single beat (2,17) -> out_acc=34 on the next cycle.
4. Backpressure: result pending with out_ready=0 for 5 cycles.
   - in_ready=0; out_* stable; queued beats not accepted.
   - On out_ready=1, the next result arrives with correct value and no duplicates.
5. ACC_WIDTH=16, three beats (-128,-128) in sat_mode=1 -> out_acc=32767, out_data=127, overflow=1.
   - Same beats in sat_mode=0 -> out_acc=-16384, out_data=0, overflow=1.
   - Next dot product (1,1,first,last) -> overflow=0.
6. Assert rst_n=0 asynchronously mid-edge after two non-last beats -> all outputs 0 immediately.
   - After release, (3,3,first,last) -> out_acc=9.

Source files
------------

// File: rtl/int_mac_if.sv
// Operand/result stream bundle for int_mac: operand beats in, dot-product results out.
interface int_mac_if #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = 20
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 first;
   logic                 last;
   logic                 sat_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_WIDTH-1:0] out_acc;
   logic [WIDTH-1:0]     out_data;
   logic                 overflow;

   modport master (
      output in_valid, a, b, first, last, sat_mode, out_ready,
      input  in_ready, out_valid, out_acc, out_data, overflow
   );

   modport slave (
      input  in_valid, a, b, first, last, sat_mode, out_ready,
      output in_ready, out_valid, out_acc, out_data, overflow
   );
endinterface

// File: rtl/int_mac.sv
// Two-stage pipelined signed multiply-accumulate with first/last framing and
// saturating or wrapping narrowing of each completed dot product.
module int_mac #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned ACC_WIDTH = 20
) (
   input  logic     clk,
   input  logic     rst_n,
   int_mac_if.slave bus
);
   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned SW = ACC_WIDTH + 1;
   localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0]            D_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0]            D_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

   if (ACC_WIDTH < PW) begin : g_bad_acc_width
      $error("int_mac: ACC_WIDTH must be >= 2*WIDTH");
   end

   logic                        advance_c;
   logic                        fire_c;
   logic signed [PW-1:0]        prod_c;
   logic signed [ACC_WIDTH-1:0] base_c;
   logic signed [SW-1:0]        sum_c;
   logic                        acc_ovf_c;
   logic signed [ACC_WIDTH-1:0] res_c;
   logic                        narrow_ovf_c;
   logic [WIDTH-1:0]            narrow_c;
   logic                        sticky_in_c;

   logic                        s1_valid_q, s1_valid_d;
   logic signed [ACC_WIDTH-1:0] s1_p_q, s1_p_d;
   logic                        s1_first_q, s1_first_d;
   logic                        s1_last_q, s1_last_d;
   logic                        s1_sat_q, s1_sat_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                        sticky_q, sticky_d;
   logic                        out_valid_q, out_valid_d;
   logic signed [ACC_WIDTH-1:0] out_acc_q, out_acc_d;
   logic [WIDTH-1:0]            out_data_q, out_data_d;
   logic                        overflow_q, overflow_d;

   // Whole pipeline moves only when the output register is free or being drained.
   assign advance_c    = !out_valid_q || bus.out_ready;
   assign fire_c       = advance_c && s1_valid_q;
   assign bus.in_ready = advance_c;

   // Stage-2 arithmetic: one guard bit detects accumulator overflow.
   always_comb begin
      prod_c       = PW'($signed(bus.a)) * PW'($signed(bus.b));
      base_c       = s1_first_q ? '0 : acc_q;
      sum_c        = SW'(base_c) + SW'(s1_p_q);
      acc_ovf_c    = sum_c[SW-1] ^ sum_c[SW-2];
      res_c        = sum_c[ACC_WIDTH-1:0];
      if (acc_ovf_c && s1_sat_q) begin
         res_c = sum_c[SW-1] ? ACC_MIN : ACC_MAX;
      end
      // Result fits in WIDTH bits only if its top bits are pure sign extension.
      narrow_ovf_c = (res_c[ACC_WIDTH-1:WIDTH-1] != '0) && (res_c[ACC_WIDTH-1:WIDTH-1] != '1);
      narrow_c     = res_c[WIDTH-1:0];
      if (narrow_ovf_c && s1_sat_q) begin
         narrow_c = res_c[ACC_WIDTH-1] ? D_MIN : D_MAX;
      end
      sticky_in_c  = (s1_first_q ? 1'b0 : sticky_q) | acc_ovf_c;
   end

   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_p_d      = s1_p_q;
      s1_first_d  = s1_first_q;
      s1_last_d   = s1_last_q;
      s1_sat_d    = s1_sat_q;
      acc_d       = acc_q;
      sticky_d    = sticky_q;
      out_valid_d = out_valid_q;
      out_acc_d   = out_acc_q;
      out_data_d  = out_data_q;
      overflow_d  = overflow_q;

      if (advance_c) begin
         s1_valid_d = bus.in_valid;
         s1_p_d     = ACC_WIDTH'(prod_c);
         s1_first_d = bus.first;
         s1_last_d  = bus.last;
         s1_sat_d   = bus.sat_mode;
      end

      if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end

      // A last beat both publishes the result and re-arms the accumulator.
      if (fire_c) begin
         if (s1_last_q) begin
            acc_d       = '0;
            sticky_d    = 1'b0;
            out_valid_d = 1'b1;
            out_acc_d   = res_c;
            out_data_d  = narrow_c;
            overflow_d  = sticky_in_c | narrow_ovf_c;
         end else begin
            acc_d       = res_c;
            sticky_d    = sticky_in_c;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q  <= 1'b0;
         s1_p_q      <= '0;
         s1_first_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_sat_q    <= 1'b0;
         acc_q       <= '0;
         sticky_q    <= 1'b0;
         out_valid_q <= 1'b0;
         out_acc_q   <= '0;
         out_data_q  <= '0;
         overflow_q  <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_p_q      <= s1_p_d;
         s1_first_q  <= s1_first_d;
         s1_last_q   <= s1_last_d;
         s1_sat_q    <= s1_sat_d;
         acc_q       <= acc_d;
         sticky_q    <= sticky_d;
         out_valid_q <= out_valid_d;
         out_acc_q   <= out_acc_d;
         out_data_q  <= out_data_d;
         overflow_q  <= overflow_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_acc   = out_acc_q;
   assign bus.out_data  = out_data_q;
   assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_int_mac.sv
// Scoreboard bench for int_mac: the same beat stream drives a 20-bit and a
// 16-bit accumulator instance; hand-computed results are checked in order.
module tb_int_mac;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   logic       drv_valid = 1'b0;
   logic [7:0] drv_a     = '0;
   logic [7:0] drv_b     = '0;
   logic       drv_first = 1'b0;
   logic       drv_last  = 1'b0;
   logic       drv_sat   = 1'b0;
   logic       drv_ready = 1'b1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      longint     acc20;
      logic [7:0] d20;
      logic       o20;
      longint     acc16;
      logic [7:0] d16;
      logic       o16;
   } exp_t;

   exp_t sb[$];

   int_mac_if #(.WIDTH(8), .ACC_WIDTH(20)) i20 ();
   int_mac_if #(.WIDTH(8), .ACC_WIDTH(16)) i16 ();

   assign i20.in_valid  = drv_valid;
   assign i20.a         = drv_a;
   assign i20.b         = drv_b;
   assign i20.first     = drv_first;
   assign i20.last      = drv_last;
   assign i20.sat_mode  = drv_sat;
   assign i20.out_ready = drv_ready;
   assign i16.in_valid  = drv_valid;
   assign i16.a         = drv_a;
   assign i16.b         = drv_b;
   assign i16.first     = drv_first;
   assign i16.last      = drv_last;
   assign i16.sat_mode  = drv_sat;
   assign i16.out_ready = drv_ready;

   int_mac #(.WIDTH(8), .ACC_WIDTH(20)) u20 (.clk(clk), .rst_n(rst_n), .bus(i20.slave));
   int_mac #(.WIDTH(8), .ACC_WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input longint a20, input logic [7:0] d20, input logic o20,
                       input longint a16, input logic [7:0] d16, input logic o16);
      exp_t e;
      e.acc20 = a20; e.d20 = d20; e.o20 = o20;
      e.acc16 = a16; e.d16 = d16; e.o16 = o16;
      sb.push_back(e);
   endtask

   task automatic push1(input longint acc, input logic [7:0] d, input logic o);
      push(acc, d, o, acc, d, o);
   endtask

   task automatic drive(input int av, input int bv, input logic f, input logic l, input logic s);
      drv_valid = 1'b1;
      drv_a     = 8'(av);
      drv_b     = 8'(bv);
      drv_first = f;
      drv_last  = l;
      drv_sat   = s;
   endtask

   // Called at posedge+#1; returns at posedge+#1 just after the beat transferred.
   task automatic wait_accept();
      int n = 0;
      @(negedge clk);
      while (!i20.in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!i20.in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      drv_valid = 1'b0;
   endtask

   task automatic send(input int av, input int bv, input logic f, input logic l, input logic s);
      drive(av, bv, f, l, s);
      wait_accept();
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (sb.size() != 0) chk("drain_timeout", longint'(sb.size()), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: a result is consumed at the edge following a negedge with valid & ready.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && i20.out_valid && drv_ready) begin
            chk("valid16", i16.out_valid, 1);
            if (sb.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("acc20",  longint'($signed(i20.out_acc)), e.acc20);
               chk("data20", i20.out_data, e.d20);
               chk("ovf20",  i20.overflow, e.o20);
               chk("acc16",  longint'($signed(i16.out_acc)), e.acc16);
               chk("data16", i16.out_data, e.d16);
               chk("ovf16",  i16.overflow, e.o16);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", i20.out_valid, 0);
      chk("rst_out_acc",   i20.out_acc, 0);
      chk("rst_out_data",  i20.out_data, 0);
      chk("rst_overflow",  i20.overflow, 0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_in_ready", i20.in_ready, 1);
      @(posedge clk);
      #1;

      // Single product, then latency check: visible only after the second edge.
      push1(-77, 8'hB3, 1'b0);
      send(-7, 11, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      chk("lat_edge1_valid", i20.out_valid, 0);
      @(negedge clk);
      chk("lat_edge2_valid", i20.out_valid, 1);
      @(posedge clk);
      #1;

      // Narrowing overflow, saturating then wrapping.
      push1(254, 8'd127, 1'b1);
      send(127, 2, 1'b1, 1'b1, 1'b1);
      push1(254, 8'hFE, 1'b1);
      send(127, 2, 1'b1, 1'b1, 1'b0);

      // Back-to-back dot product, then a non-first last beat starts from zero.
      push1(23, 8'd23, 1'b0);
      send(2, 17, 1'b1, 1'b0, 1'b1);
      send(3, -4, 1'b0, 1'b0, 1'b1);
      send(-1, -1, 1'b0, 1'b1, 1'b1);
      push1(34, 8'd34, 1'b0);
      send(2, 17, 1'b0, 1'b1, 1'b1);
      drain();

      // Backpressure: result A held, B parked in stage 1, C refused.
      drv_ready = 1'b0;
      push1(30, 8'd30, 1'b0);
      send(5, 6, 1'b1, 1'b1, 1'b1);
      push1(2, 8'd2, 1'b0);
      send(1, 2, 1'b1, 1'b1, 1'b1);
      push1(12, 8'd12, 1'b0);
      drive(3, 4, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_in_ready",  i20.in_ready, 0);
         chk("stall_out_valid", i20.out_valid, 1);
         chk("stall_out_acc",   longint'($signed(i20.out_acc)), 30);
      end
      @(posedge clk);
      #1;
      drv_ready = 1'b1;
      wait_accept();
      drain();

      // Accumulator overflow: differs between the 20-bit and 16-bit instances.
      push(49152, 8'd127, 1'b1, 32767, 8'd127, 1'b1);
      send(-128, -128, 1'b1, 1'b0, 1'b1);
      send(-128, -128, 1'b0, 1'b0, 1'b1);
      send(-128, -128, 1'b0, 1'b1, 1'b1);
      push(49152, 8'd0, 1'b1, -16384, 8'd0, 1'b1);
      send(-128, -128, 1'b1, 1'b0, 1'b0);
      send(-128, -128, 1'b0, 1'b0, 1'b0);
      send(-128, -128, 1'b0, 1'b1, 1'b0);
      push1(1, 8'd1, 1'b0);
      send(1, 1, 1'b1, 1'b1, 1'b1);
      drain();

      // Asynchronous reset mid-accumulation clears outputs at once.
      send(1, 1, 1'b1, 1'b0, 1'b1);
      send(2, 2, 1'b0, 1'b0, 1'b1);
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", i20.out_valid, 0);
      chk("async_rst_out_acc",   i20.out_acc, 0);
      chk("async_rst_out_data",  i20.out_data, 0);
      chk("async_rst_overflow",  i16.overflow, 0);
      chk("async_rst_acc16",     i16.out_acc, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      push1(9, 8'd9, 1'b0);
      send(3, 3, 1'b1, 1'b1, 1'b1);
      push1(4, 8'd4, 1'b0);
      send(2, 2, 1'b0, 1'b1, 1'b1);
      drain();

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", longint'(sb.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
